// File: rtl/spider_motion_ctrl_if.sv
// Signal bundle between the spider motion controller, its game-side inputs and the sprite drawer.
// The controller takes the master view; the game FSM / drawer side takes the slave view.
interface spider_motion_ctrl_if;
   logic       frame_tick;
   logic       game_active;
   logic       hit;
   logic [9:0] spider_x;
   logic [9:0] spider_y;
   logic       spider_alive;
   logic       kill_pulse;
   logic       escape_pulse;

   modport master (
      input  frame_tick, game_active, hit,
      output spider_x, spider_y, spider_alive, kill_pulse, escape_pulse
   );

   modport slave (
      output frame_tick, game_active, hit,
      input  spider_x, spider_y, spider_alive, kill_pulse, escape_pulse
   );
endinterface

// File: rtl/spider_motion_ctrl.sv
// Per-frame state machine for one spider enemy: zig-zag descent, kill/escape events,
// and respawn at a pseudo-random column after a fixed number of dead frames.
module spider_motion_ctrl #(
   parameter int unsigned SCREEN_W       = 640,
   parameter int unsigned SCREEN_H       = 480,
   parameter int unsigned SPRITE_W       = 32,
   parameter int unsigned SPEED_X        = 2,
   parameter int unsigned DROP_Y         = 16,
   parameter int unsigned START_Y        = 32,
   parameter int unsigned RESPAWN_FRAMES = 60,
   parameter logic [9:0]  LFSR_SEED      = 10'h2A5
) (
   input logic                  clk,
   input logic                  rst_n,
   spider_motion_ctrl_if.master spider_if
);

   // Counter wide enough for RESPAWN_FRAMES, and at least one bit when it is zero.
   localparam int unsigned      CNT_W     = $clog2(RESPAWN_FRAMES + 2);
   localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(RESPAWN_FRAMES);
   localparam logic [10:0]      MAX_X_W   = 11'(SCREEN_W - SPRITE_W);
   localparam logic [10:0]      ESC_Y_W   = 11'(SCREEN_H - SPRITE_W);
   localparam logic [10:0]      SPEED_W   = 11'(SPEED_X);
   localparam logic [10:0]      DROP_W    = 11'(DROP_Y);
   localparam logic [9:0]       START_Y_W = 10'(START_Y);

   typedef enum logic {
      ST_WAIT  = 1'b0,
      ST_ALIVE = 1'b1
   } state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             dir_q, dir_d;
   logic [9:0]       x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic [9:0]       lfsr_q, lfsr_d;
   logic             alive_q, alive_d;
   logic             kill_q, kill_d;
   logic             esc_q, esc_d;

   logic [10:0]      x_w;
   logic [10:0]      y_w;
   logic [10:0]      y_new;

   // One subtraction folds any 10-bit value into 0..MAX_X because 1023-MAX_X < MAX_X.
   function automatic logic [9:0] fold_col(input logic [9:0] v);
      logic [10:0] vw;
      vw = {1'b0, v};
      return (vw > MAX_X_W) ? 10'(vw - MAX_X_W) : v;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      x_d     = x_q;
      y_d     = y_q;
      alive_d = alive_q;
      kill_d  = 1'b0;
      esc_d   = 1'b0;
      x_w     = {1'b0, x_q};
      y_w     = {1'b0, y_q};
      y_new   = y_w;
      lfsr_d  = spider_if.frame_tick ? {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]} : lfsr_q;

      if (!spider_if.game_active) begin
         state_d = ST_WAIT;
         cnt_d   = CNT_INIT;
         alive_d = 1'b0;
      end else begin
         unique case (state_q)
            ST_WAIT: begin
               if (spider_if.frame_tick) begin
                  if (cnt_q != '0) begin
                     cnt_d = cnt_q - CNT_W'(1);
                  end else begin
                     x_d     = fold_col(lfsr_q);
                     y_d     = START_Y_W;
                     dir_d   = lfsr_q[0];
                     alive_d = 1'b1;
                     state_d = ST_ALIVE;
                  end
               end
            end

            ST_ALIVE: begin
               // A hit freezes position for the frame even if a tick arrives alongside it.
               if (spider_if.hit) begin
                  alive_d = 1'b0;
                  kill_d  = 1'b1;
                  state_d = ST_WAIT;
                  cnt_d   = CNT_INIT;
               end else if (spider_if.frame_tick) begin
                  if (!dir_q) begin
                     if (x_w + SPEED_W >= MAX_X_W) begin
                        x_d   = MAX_X_W[9:0];
                        dir_d = 1'b1;
                        y_new = y_w + DROP_W;
                     end else begin
                        x_d = 10'(x_w + SPEED_W);
                     end
                  end else begin
                     if (x_w <= SPEED_W) begin
                        x_d   = '0;
                        dir_d = 1'b0;
                        y_new = y_w + DROP_W;
                     end else begin
                        x_d = 10'(x_w - SPEED_W);
                     end
                  end
                  y_d = y_new[9:0];
                  if (y_new >= ESC_Y_W) begin
                     alive_d = 1'b0;
                     esc_d   = 1'b1;
                     state_d = ST_WAIT;
                     cnt_d   = CNT_INIT;
                  end
               end
            end

            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_WAIT;
         cnt_q   <= CNT_INIT;
         dir_q   <= 1'b0;
         x_q     <= '0;
         y_q     <= START_Y_W;
         lfsr_q  <= LFSR_SEED;
         alive_q <= 1'b0;
         kill_q  <= 1'b0;
         esc_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
         x_q     <= x_d;
         y_q     <= y_d;
         lfsr_q  <= lfsr_d;
         alive_q <= alive_d;
         kill_q  <= kill_d;
         esc_q   <= esc_d;
      end
   end

   assign spider_if.spider_x     = x_q;
   assign spider_if.spider_y     = y_q;
   assign spider_if.spider_alive = alive_q;
   assign spider_if.kill_pulse   = kill_q;
   assign spider_if.escape_pulse = esc_q;

endmodule

// File: tb/tb_spider_motion_ctrl.sv
// Directed bench for spider_motion_ctrl: two instances (respawn delay 3 and 0, seed 600)
// driven through spawn, zig-zag, kill, escape, game_active drop and async reset.
module tb_spider_motion_ctrl;
   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   logic [9:0] lfsr_a;
   logic [9:0] lfsr_b;
   logic [9:0] pre;

   spider_motion_ctrl_if ifa ();
   spider_motion_ctrl_if ifb ();

   spider_motion_ctrl #(.RESPAWN_FRAMES(3), .LFSR_SEED(10'd600)) dut_a (
      .clk      (clk),
      .rst_n    (rst_n),
      .spider_if(ifa)
   );

   spider_motion_ctrl #(.RESPAWN_FRAMES(0), .LFSR_SEED(10'd600)) dut_b (
      .clk      (clk),
      .rst_n    (rst_n),
      .spider_if(ifb)
   );

   always #5 clk = ~clk;

   function automatic logic [9:0] lfsr_step(input logic [9:0] v);
      return {v[8:0], v[9] ^ v[6]};
   endfunction

   function automatic logic [9:0] col_of(input logic [9:0] v);
      return (v > 10'd608) ? v - 10'd608 : v;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic tick_a(input int n);
      ifa.frame_tick = 1'b1;
      repeat (n) begin
         @(posedge clk);
         lfsr_a = lfsr_step(lfsr_a);
      end
      #1;
      ifa.frame_tick = 1'b0;
   endtask

   task automatic tick_b(input int n);
      ifb.frame_tick = 1'b1;
      repeat (n) begin
         @(posedge clk);
         lfsr_b = lfsr_step(lfsr_b);
      end
      #1;
      ifb.frame_tick = 1'b0;
   endtask

   task automatic chk_reset(input string who, input logic [9:0] x, input logic [9:0] y,
                            input logic al, input logic kp, input logic ep);
      chk({who, "_rst_x"},     32'(x),  32'd0);
      chk({who, "_rst_y"},     32'(y),  32'd32);
      chk({who, "_rst_alive"}, 32'(al), 32'd0);
      chk({who, "_rst_kill"},  32'(kp), 32'd0);
      chk({who, "_rst_esc"},   32'(ep), 32'd0);
   endtask

   initial begin
      rst_n           = 1'b0;
      ifa.frame_tick  = 1'b0;
      ifa.game_active = 1'b1;
      ifa.hit         = 1'b0;
      ifb.frame_tick  = 1'b0;
      ifb.game_active = 1'b1;
      ifb.hit         = 1'b0;
      lfsr_a          = 10'd600;
      lfsr_b          = 10'd600;

      #12;
      chk_reset("a", ifa.spider_x, ifa.spider_y, ifa.spider_alive, ifa.kill_pulse, ifa.escape_pulse);
      chk_reset("b", ifb.spider_x, ifb.spider_y, ifb.spider_alive, ifb.kill_pulse, ifb.escape_pulse);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1);

      // Instance A: three dead ticks, spawn on the fourth from LFSR 705 -> column 97, moving left.
      tick_a(1); chk("a_dead_t1", 32'(ifa.spider_alive), 32'd0);
      tick_a(1); chk("a_dead_t2", 32'(ifa.spider_alive), 32'd0);
      tick_a(1); chk("a_dead_t3", 32'(ifa.spider_alive), 32'd0);
      tick_a(1);
      chk("a_spawn_alive", 32'(ifa.spider_alive), 32'd1);
      chk("a_spawn_x",     32'(ifa.spider_x),     32'd97);
      chk("a_spawn_y",     32'(ifa.spider_y),     32'd32);
      tick_a(1);
      chk("a_move_left_x", 32'(ifa.spider_x), 32'd95);

      // game_active low: dead next cycle, no pulses, position held.
      ifa.game_active = 1'b0;
      cyc(1);
      ifa.game_active = 1'b1;
      chk("a_inactive_alive", 32'(ifa.spider_alive), 32'd0);
      chk("a_inactive_kill",  32'(ifa.kill_pulse),   32'd0);
      chk("a_inactive_esc",   32'(ifa.escape_pulse), 32'd0);
      chk("a_inactive_x",     32'(ifa.spider_x),     32'd95);
      tick_a(1); chk("a_reactive_t1", 32'(ifa.spider_alive), 32'd0);
      tick_a(1); chk("a_reactive_t2", 32'(ifa.spider_alive), 32'd0);
      tick_a(1); chk("a_reactive_t3", 32'(ifa.spider_alive), 32'd0);
      pre = lfsr_a;
      tick_a(1);
      chk("a_respawn_alive", 32'(ifa.spider_alive), 32'd1);
      chk("a_respawn_x",     32'(ifa.spider_x),     32'(col_of(pre)));
      chk("a_respawn_y",     32'(ifa.spider_y),     32'd32);

      // Hit together with a tick: kill wins, no movement.
      ifa.hit = 1'b1;
      tick_a(1);
      ifa.hit = 1'b0;
      chk("a_kill_pulse", 32'(ifa.kill_pulse),   32'd1);
      chk("a_kill_alive", 32'(ifa.spider_alive), 32'd0);
      chk("a_kill_x",     32'(ifa.spider_x),     32'(col_of(pre)));
      chk("a_kill_y",     32'(ifa.spider_y),     32'd32);
      chk("a_kill_esc",   32'(ifa.escape_pulse), 32'd0);
      ifa.hit = 1'b1;
      cyc(1);
      ifa.hit = 1'b0;
      chk("a_kill_one_cycle", 32'(ifa.kill_pulse), 32'd0);
      cyc(1);
      chk("a_wait_hit_nopulse", 32'(ifa.kill_pulse), 32'd0);

      // Instance B: zero respawn delay, spawns at the seed column moving right.
      tick_b(1);
      chk("b_spawn_alive", 32'(ifb.spider_alive), 32'd1);
      chk("b_spawn_x",     32'(ifb.spider_x),     32'd600);
      chk("b_spawn_y",     32'(ifb.spider_y),     32'd32);
      tick_b(1); chk("b_x602", 32'(ifb.spider_x), 32'd602);
      tick_b(1); chk("b_x604", 32'(ifb.spider_x), 32'd604);
      tick_b(1); chk("b_x606", 32'(ifb.spider_x), 32'd606);
      tick_b(1);
      chk("b_redge_x", 32'(ifb.spider_x), 32'd608);
      chk("b_redge_y", 32'(ifb.spider_y), 32'd48);
      tick_b(1);
      chk("b_left_x", 32'(ifb.spider_x), 32'd606);
      chk("b_left_y", 32'(ifb.spider_y), 32'd48);

      // 302 steps reach x=2, the 303rd reverses at the left edge.
      tick_b(303);
      chk("b_ledge_x", 32'(ifb.spider_x), 32'd0);
      chk("b_ledge_y", 32'(ifb.spider_y), 32'd64);
      // Each further reversal takes 304 ticks; 23 more reach y=432 at the right edge.
      tick_b(304 * 23);
      chk("b_y432_x",     32'(ifb.spider_x),     32'd608);
      chk("b_y432_y",     32'(ifb.spider_y),     32'd432);
      chk("b_y432_alive", 32'(ifb.spider_alive), 32'd1);
      tick_b(304);
      chk("b_esc_pulse", 32'(ifb.escape_pulse), 32'd1);
      chk("b_esc_alive", 32'(ifb.spider_alive), 32'd0);
      chk("b_esc_kill",  32'(ifb.kill_pulse),   32'd0);
      chk("b_esc_x",     32'(ifb.spider_x),     32'd0);
      chk("b_esc_y",     32'(ifb.spider_y),     32'd448);
      cyc(1);
      chk("b_esc_one_cycle", 32'(ifb.escape_pulse), 32'd0);

      // Respawn, then hit so kill_pulse is high when reset drops mid-cycle.
      pre = lfsr_b;
      tick_b(1);
      chk("b_respawn_alive", 32'(ifb.spider_alive), 32'd1);
      chk("b_respawn_x",     32'(ifb.spider_x),     32'(col_of(pre)));
      ifb.hit = 1'b1;
      cyc(1);
      ifb.hit = 1'b0;
      chk("b_kill_pulse", 32'(ifb.kill_pulse), 32'd1);
      #3;
      rst_n = 1'b0;
      #1;
      chk_reset("b_async", ifb.spider_x, ifb.spider_y, ifb.spider_alive, ifb.kill_pulse, ifb.escape_pulse);
      chk_reset("a_async", ifa.spider_x, ifa.spider_y, ifa.spider_alive, ifa.kill_pulse, ifa.escape_pulse);
      lfsr_a = 10'd600;
      lfsr_b = 10'd600;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(1);
      // LFSR reloaded: immediate respawn lands on the seed column again.
      tick_b(1);
      chk("b_reseed_x",     32'(ifb.spider_x),     32'd600);
      chk("b_reseed_alive", 32'(ifb.spider_alive), 32'd1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
